// File: rtl/loader_defs.sv
// Shared definitions for the RAM preload/dump engine: state encoding,
// operation modes and default geometry.
package loader_defs;

    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_BYTE_W     = 8;
    localparam int DEF_WORD_BYTES = 4;

    localparam logic MODE_LOAD = 1'b0;
    localparam logic MODE_DUMP = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_CAPT  = 3'd3,
        ST_OUT      = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

endpackage

// File: rtl/word_packer.sv
// Byte-to-word shift register for the dump path: the first byte shifted in
// ends up in the most significant byte once WORD_BYTES bytes are gathered.
module word_packer #(
    parameter int BYTE_W     = 8,
    parameter int WORD_BYTES = 4,
    parameter int CNT_W      = $clog2(WORD_BYTES + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         shift_en,
    input  logic [BYTE_W-1:0]            byte_in,
    output logic [BYTE_W*WORD_BYTES-1:0] word,
    output logic [CNT_W-1:0]             count,
    output logic                         full
);

    logic [BYTE_W-1:0] byte_reg [WORD_BYTES];
    logic [CNT_W-1:0]  cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                byte_reg[i] <= '0;
            end
        end else if (shift_en) begin
            byte_reg[0] <= byte_in;
            for (int i = 1; i < WORD_BYTES; i++) begin
                byte_reg[i] <= byte_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (shift_en) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_word
            assign word[gi*BYTE_W +: BYTE_W] = byte_reg[gi];
        end
    endgenerate

    assign count = cnt_reg;
    assign full  = (cnt_reg == CNT_W'(WORD_BYTES));

endmodule

// File: rtl/ram_loader.sv
// RAM preload (byte stream -> RAM) and dump (RAM -> big-endian words) engine.
// Keeps the CPU held in reset until a load has completed.
module ram_loader
    import loader_defs::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BYTE_W     = DEF_BYTE_W,
    parameter int WORD_BYTES = DEF_WORD_BYTES,
    parameter int BASE_ADDR  = 0
) (
    input  logic                         main_clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         mode,
    input  logic [ADDR_WIDTH:0]          length,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BYTE_W-1:0]            in_data,
    output logic                         mem_we,
    output logic                         mem_re,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [BYTE_W-1:0]            mem_wdata,
    input  logic [BYTE_W-1:0]            mem_rdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BYTE_W*WORD_BYTES-1:0] out_data,
    output logic [ADDR_WIDTH-1:0]        out_addr,
    output logic                         busy,
    output logic                         done,
    output logic                         cpu_hold,
    output logic [BYTE_W-1:0]            checksum,
    output logic                         len_err
);

    localparam int DEPTH    = 2 ** ADDR_WIDTH;
    localparam int LEN_W    = ADDR_WIDTH + 1;
    localparam int WORD_W   = BYTE_W * WORD_BYTES;
    localparam int PK_CNT_W = $clog2(WORD_BYTES + 1);

    localparam logic [LEN_W-1:0]      DEPTH_L = LEN_W'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BASE_L  = ADDR_WIDTH'(BASE_ADDR % DEPTH);

    state_t            state_reg, state_next;
    logic              mode_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  cnt_reg;
    logic [BYTE_W-1:0] checksum_reg;
    logic              len_err_reg;
    logic              cpu_hold_reg;
    logic              hold_prev_reg;

    logic [LEN_W-1:0]      eff_len;
    logic [LEN_W-1:0]      dump_len;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  start_take;

    logic                pk_clr;
    logic                pk_shift;
    logic [WORD_W-1:0]   pk_word;
    logic [PK_CNT_W-1:0] pk_count;
    logic                pk_full;

    // Oversized requests are clamped; a dump only moves whole words.
    assign eff_len    = (length > DEPTH_L) ? DEPTH_L : length;
    assign dump_len   = LEN_W'((32'(eff_len) / WORD_BYTES) * WORD_BYTES);
    assign cur_addr   = BASE_L + cnt_reg[ADDR_WIDTH-1:0];
    assign start_take = (state_reg == ST_IDLE) && start;

    word_packer #(
        .BYTE_W    (BYTE_W),
        .WORD_BYTES(WORD_BYTES),
        .CNT_W     (PK_CNT_W)
    ) u_packer (
        .clk     (main_clk),
        .rst_n   (reset),
        .clr     (pk_clr),
        .shift_en(pk_shift),
        .byte_in (mem_rdata),
        .word    (pk_word),
        .count   (pk_count),
        .full    (pk_full)
    );

    always_ff @(posedge main_clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_addr   = '0;
        done       = 1'b0;
        pk_clr     = 1'b0;
        pk_shift   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    pk_clr = 1'b1;
                    if (mode == MODE_DUMP) begin
                        state_next = (dump_len == '0) ? ST_DONE : ST_RD_ISSUE;
                    end else begin
                        state_next = (eff_len == '0) ? ST_DONE : ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_we    = 1'b1;
                    mem_addr  = cur_addr;
                    mem_wdata = in_data;
                    if ((cnt_reg + LEN_W'(1)) == len_reg) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_RD_ISSUE: begin
                mem_re     = 1'b1;
                mem_addr   = cur_addr;
                state_next = ST_RD_CAPT;
            end
            ST_RD_CAPT: begin
                pk_shift   = 1'b1;
                state_next = (pk_count == PK_CNT_W'(WORD_BYTES - 1)) ? ST_OUT : ST_RD_ISSUE;
            end
            ST_OUT: begin
                // cnt_reg already points past the word, so step back to its first byte
                out_valid = pk_full;
                out_data  = pk_word;
                out_addr  = cur_addr - ADDR_WIDTH'(WORD_BYTES);
                if (out_ready) begin
                    pk_clr     = 1'b1;
                    state_next = (cnt_reg == len_reg) ? ST_DONE : ST_RD_ISSUE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge main_clk or negedge reset) begin
        if (!reset) begin
            mode_reg      <= MODE_LOAD;
            len_reg       <= '0;
            cnt_reg       <= '0;
            checksum_reg  <= '0;
            len_err_reg   <= 1'b0;
            cpu_hold_reg  <= 1'b1;
            hold_prev_reg <= 1'b1;
        end else begin
            if (start_take) begin
                mode_reg      <= mode;
                len_reg       <= (mode == MODE_DUMP) ? dump_len : eff_len;
                cnt_reg       <= '0;
                checksum_reg  <= '0;
                len_err_reg   <= (length > DEPTH_L);
                cpu_hold_reg  <= 1'b1;
                hold_prev_reg <= cpu_hold_reg;
            end
            if (mem_we) begin
                cnt_reg      <= cnt_reg + LEN_W'(1);
                checksum_reg <= checksum_reg + in_data;
            end
            if (pk_shift) begin
                cnt_reg      <= cnt_reg + LEN_W'(1);
                checksum_reg <= checksum_reg + mem_rdata;
            end
            // A dump leaves the hold exactly as it was before its start
            if (state_reg == ST_DONE) begin
                cpu_hold_reg <= (mode_reg == MODE_LOAD) ? 1'b0 : hold_prev_reg;
            end
        end
    end

    assign busy     = (state_reg != ST_IDLE);
    assign cpu_hold = cpu_hold_reg;
    assign checksum = checksum_reg;
    assign len_err  = len_err_reg;

endmodule
